dbus_mem_responder: RTL and testbench

- Responder (slave) end of the data-bus request/response protocol driven by the core: accepts `dbus_req_t`, returns `dbus_resp_t`.
- Backs a word-addressed 64-bit data memory with byte strobes and a programmable response latency.
- Used as the simulation/FPGA data memory behind the core and as the reference model for core memory-stage verification.

---
 rtl/dbus_mem_responder_pkg.sv | 39 +++
 rtl/dbus_mem_responder_if.sv | 12 +
 rtl/dbus_mem_responder_sram_be64.sv | 30 +++
 rtl/dbus_mem_responder.sv | 123 ++++++++++++
 tb/tb_dbus_mem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// Shared data-bus types for the memory responder: request/response
// structs, access size encoding, responder FSM states and widths.
package dbus_mem_responder_pkg;

  // Access size, log2 of the byte count.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Request presented by the core.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  // Response returned to the core.
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Width of the latency counter; holds LATENCY-1 for LATENCY up to 15.
  localparam int DMEM_LAT_W = 4;

endpackage

// File: rtl/dbus_mem_responder_if.sv
// Data-bus request/response bundle between the core (master) and the
// memory responder (slave).
interface dbus_mem_responder_if;
  import dbus_mem_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_mem_responder_sram_be64.sv
// MEM_WORDS x 64-bit array: synchronous byte-enabled write,
// combinational read of the addressed word.
module sram_be64 #(
  parameter  int MEM_WORDS = 1024,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem [MEM_WORDS];

  // Byte-lane write of the addressed word.
  // NOTE: the array has no reset on purpose; its contents survive rst and
  // a reset term would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus responder: accepts one request at a time, waits LATENCY cycles,
// then returns a single-cycle response carrying the pre-write word.
// Writes commit on the edge leaving RESP; out-of-range accesses complete
// normally but read zero, drop the write and set the sticky err flag.
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dbus_mem_responder_if.slave  bus,
  output logic                 err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [DMEM_LAT_W-1:0] LAT_INIT = DMEM_LAT_W'(LATENCY - 1);
  localparam logic [DMEM_LAT_W-1:0] LAT_ONE  = DMEM_LAT_W'(1);

  // True when the byte address falls inside the array window.
  function automatic logic addr_in_range(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off[63:IDX_W+3] == '0);
  endfunction

  dmem_state_t           state;
  logic [DMEM_LAT_W-1:0] cnt;
  logic [63:0]           cap_addr;
  logic [7:0]            cap_strobe;
  logic [63:0]           cap_data;
  msize_t                cap_size;
  logic                  cap_in_range;
  dbus_resp_t            resp_q;

  logic [63:0]      sel_addr;
  logic [63:0]      sel_off;
  logic [IDX_W-1:0] mem_idx;
  logic [63:0]      mem_rdata;
  logic             mem_we;
  logic             req_in_range;

  // In IDLE the array is indexed straight from the bus so a LATENCY=1
  // response can be registered on the acceptance edge; afterwards the
  // captured address drives it for the rest of the transaction.
  assign sel_addr     = (state == IDLE) ? bus.dreq.addr : cap_addr;
  assign sel_off      = sel_addr - BASE_ADDR;
  assign mem_idx      = sel_off[IDX_W+2:3];
  assign req_in_range = addr_in_range(bus.dreq.addr);

  // The write lands on the edge that leaves RESP, after the old word
  // has already been registered into the response.
  assign mem_we = (state == RESP) && (cap_strobe != 8'h00) && cap_in_range;

  sram_be64 #(.MEM_WORDS(MEM_WORDS)) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .be    (cap_strobe),
    .idx   (mem_idx),
    .wdata (cap_data),
    .rdata (mem_rdata)
  );

  // Request FSM, latency counter, captured request and registered response.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_addr     <= '0;
      cap_strobe   <= '0;
      cap_data     <= '0;
      cap_size     <= MSIZE1;
      cap_in_range <= 1'b0;
      resp_q       <= '0;
      err          <= 1'b0;
    end else begin
      // Response is low everywhere except the single RESP cycle.
      resp_q <= '0;
      case (state)
        IDLE: begin
          if (bus.dreq.valid) begin
            cap_addr     <= bus.dreq.addr;
            cap_strobe   <= bus.dreq.strobe;
            cap_data     <= bus.dreq.data;
            cap_size     <= bus.dreq.size;
            cap_in_range <= req_in_range;
            err          <= err | ~req_in_range;
            if (LATENCY == 1) begin
              state          <= RESP;
              cnt            <= '0;
              resp_q.addr_ok <= 1'b1;
              resp_q.data_ok <= 1'b1;
              resp_q.data    <= req_in_range ? mem_rdata : 64'h0;
            end else begin
              state <= BUSY;
              cnt   <= LAT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt <= LAT_ONE) begin
            state          <= RESP;
            cnt            <= '0;
            resp_q.addr_ok <= 1'b1;
            resp_q.data_ok <= 1'b1;
            resp_q.data    <= cap_in_range ? mem_rdata : 64'h0;
          end else begin
            cnt <= cnt - LAT_ONE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dresp = resp_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder: a LATENCY=2 instance for the
// directed cases and a LATENCY=1 instance for a scoreboarded random sweep.
module tb_dbus_mem_responder;
  import dbus_mem_responder_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          WORDS = 1024;

  logic clk;
  logic rst;
  logic err2, err1;
  logic sel;          // 0: drive/observe LATENCY=2 instance, 1: LATENCY=1
  int   cyc;
  int   n_assert;
  int   n_fail;

  dbus_req_t  dreq_drv;
  dbus_req_t  idle_req;
  dbus_resp_t cur_resp;
  logic       cur_err;

  dbus_mem_responder_if bus2 ();
  dbus_mem_responder_if bus1 ();

  dbus_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2), .err (err2)
  );
  dbus_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .err (err1)
  );

  assign idle_req  = '0;
  assign bus2.dreq = sel ? idle_req : dreq_drv;
  assign bus1.dreq = sel ? dreq_drv : idle_req;
  assign cur_resp  = sel ? bus1.dresp : bus2.dresp;
  assign cur_err   = sel ? err1 : err2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction, starting and ending just after a clock edge.
  // lat is the number of edges from acceptance (inclusive) to the edge that
  // raises data_ok; 0 means no response within the bound.
  task automatic txn(input logic [63:0] a, input logic [7:0] sb, input logic [63:0] d,
                     output logic [63:0] rd, output int lat, output logic aok);
    dreq_drv = '{valid: 1'b1, addr: a, size: MSIZE8, strobe: sb, data: d};
    @(posedge clk); #1;
    // Garbage on the bus after acceptance must be ignored.
    dreq_drv = '{valid: 1'b0, addr: ~a, size: MSIZE1, strobe: ~sb, data: ~d};
    lat = 0;
    rd  = '0;
    aok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (cur_resp.data_ok) begin
        lat = i;
        rd  = cur_resp.data;
        aok = cur_resp.addr_ok;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [63:0] rd;
  int          lat;
  logic        aok;
  int          t1, t2;
  logic [63:0] model [16];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    sel      = 1'b0;
    dreq_drv = '0;
    rst      = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", 64'(cur_resp.addr_ok), 64'h0);
    check("rst_data_ok", 64'(cur_resp.data_ok), 64'h0);
    check("rst_data", cur_resp.data, 64'h0);
    check("rst_err", 64'(cur_err), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Preload words.
    txn(BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, rd, lat, aok);
    check("preload_lat", 64'(lat), 64'd2);
    txn(BASE + 64'h18, 8'hFF, 64'h1111_2222_3333_4444, rd, lat, aok);
    txn(BASE + 64'h00, 8'hFF, 64'h5555_6666_7777_8888, rd, lat, aok);
    txn(BASE + 64'h28, 8'hFF, 64'hCAFE_F00D_1234_5678, rd, lat, aok);

    // Read with cycle-exact response window.
    dreq_drv = '{valid: 1'b1, addr: BASE + 64'h10, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    @(posedge clk); #1;
    dreq_drv = '0;
    check("rd_e0_data_ok", 64'(cur_resp.data_ok), 64'h0);
    check("rd_e0_addr_ok", 64'(cur_resp.addr_ok), 64'h0);
    @(posedge clk); #1;
    check("rd_e1_data_ok", 64'(cur_resp.data_ok), 64'h1);
    check("rd_e1_addr_ok", 64'(cur_resp.addr_ok), 64'h1);
    check("rd_e1_data", cur_resp.data, 64'h1122_3344_5566_7788);
    @(posedge clk); #1;
    check("rd_e2_data_ok", 64'(cur_resp.data_ok), 64'h0);
    check("rd_e2_addr_ok", 64'(cur_resp.addr_ok), 64'h0);
    check("rd_e2_data", cur_resp.data, 64'h0);

    // Partial-strobe write returns the old word, then read back merged.
    txn(BASE + 64'h18, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, rd, lat, aok);
    check("wr_lat", 64'(lat), 64'd2);
    check("wr_addr_ok", 64'(aok), 64'h1);
    check("wr_old_data", rd, 64'h1111_2222_3333_4444);
    txn(BASE + 64'h18, 8'h00, 64'h0, rd, lat, aok);
    check("wr_merged", rd, 64'h1111_2222_CCCC_DDDD);

    // Back-to-back write then read with valid held high.
    t1 = -100;
    t2 = 0;
    rd = '0;
    dreq_drv = '{valid: 1'b1, addr: BASE + 64'h20, size: MSIZE8, strobe: 8'hFF,
                 data: 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cur_resp.data_ok) begin
        t1 = cyc;
        break;
      end
    end
    dreq_drv = '{valid: 1'b1, addr: BASE + 64'h20, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cur_resp.data_ok) begin
        t2 = cyc;
        rd = cur_resp.data;
        break;
      end
    end
    dreq_drv = '0;
    @(posedge clk); #1;
    check("b2b_gap", 64'(t2 - t1), 64'd3);
    check("b2b_data", rd, 64'h0123_4567_89AB_CDEF);

    // Out-of-range read and write.
    txn(64'h0, 8'h00, 64'h0, rd, lat, aok);
    check("oor_rd_lat", 64'(lat), 64'd2);
    check("oor_rd_data", rd, 64'h0);
    check("oor_rd_err", 64'(cur_err), 64'h1);
    txn(BASE + 64'(8 * WORDS), 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, lat, aok);
    check("oor_wr_lat", 64'(lat), 64'd2);
    check("oor_wr_err", 64'(cur_err), 64'h1);
    txn(BASE + 64'h00, 8'h00, 64'h0, rd, lat, aok);
    check("oor_mem_kept", rd, 64'h5555_6666_7777_8888);

    // Reset while BUSY on a full write.
    dreq_drv = '{valid: 1'b1, addr: BASE + 64'h28, size: MSIZE8, strobe: 8'hFF, data: 64'h0};
    @(posedge clk); #1;
    dreq_drv = '0;
    rst = 1'b0;
    #1;
    check("midrst_data_ok", 64'(cur_resp.data_ok), 64'h0);
    check("midrst_addr_ok", 64'(cur_resp.addr_ok), 64'h0);
    check("midrst_data", cur_resp.data, 64'h0);
    check("midrst_err", 64'(cur_err), 64'h0);
    @(posedge clk); #1;
    check("midrst_hold_data_ok", 64'(cur_resp.data_ok), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_data_ok", 64'(cur_resp.data_ok), 64'h0);
    txn(BASE + 64'h28, 8'h00, 64'h0, rd, lat, aok);
    check("postrst_lat", 64'(lat), 64'd2);
    check("postrst_word_kept", rd, 64'hCAFE_F00D_1234_5678);

    // LATENCY=1 random sweep against a scoreboard.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      model[i] = {$urandom, $urandom};
      txn(BASE + 64'(8 * i), 8'hFF, model[i], rd, lat, aok);
    end
    for (int n = 0; n < 100; n++) begin
      int          wi;
      logic [7:0]  sb;
      logic [63:0] d;
      wi = $urandom_range(0, 15);
      sb = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      d  = {$urandom, $urandom};
      txn(BASE + 64'(8 * wi), sb, d, rd, lat, aok);
      check("sweep_lat", 64'(lat), 64'd1);
      check("sweep_data", rd, model[wi]);
      for (int b = 0; b < 8; b++) begin
        if (sb[b]) model[wi][8*b +: 8] = d[8*b +: 8];
      end
    end
    check("sweep_err", 64'(cur_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
